servo_frame_gen: RTL and testbench
==================================

Name: servo_frame_gen

Overview:
Upstream stage of the per-axis servo PWM comparators. It generates the shared 20 ms frame timebase `cntr_val` at 1 µs resolution, so one frame is 20000 ticks and a pulse width of 1000 ticks is 1 ms. It converts the raw SPI joystick sample into the pulse-width setpoint `x_val` (1000..2000 ticks) with clamping and per-frame slew limiting. The PWM comparator drives high while `cntr_val < x_val`. `x_val` is updated only at frame boundaries, so no pulse is ever truncated or glitched.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- TICK_HZ, 1_000_000, timebase tick rate. CLK_HZ/TICK_HZ must be an integer ≥ 2.
- FRAME_TICKS, 20000, ticks per PWM frame. Must be ≤ 32768.
- PULSE_MIN, 1000, setpoint for raw sample 0.
- PULSE_SPAN, 1000, maximum raw value. Raw samples above this are clamped to it.
- SLEW_STEP, 50, maximum change of `x_val` per frame, in ticks.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-low reset.
- en, in, 1, timebase enable.
- spi_data, in, 10, raw sample from the SPI receiver.
- spi_valid, in, 1, one-cycle strobe; `spi_data` is valid in this cycle.
- cntr_val, out, 15, frame tick counter, range 0..FRAME_TICKS-1.
- x_val, out, 11, pulse-width setpoint in ticks.
- frame_start, out, 1, one-cycle pulse, high in the cycle `cntr_val` becomes 0 by wrap.
- slewing, out, 1, high while `x_val` ≠ target.

Behaviour:
- Reset (`rst` = 0, asynchronous assert; deassert sampled on `clk`):
  - prescaler = 0, `cntr_val` = 0, `frame_start` = 0.
  - target = `x_val` = PULSE_MIN + PULSE_SPAN/2 (1500).
  - `slewing` = 0.
- All outputs are registered.
- Prescaler:
  - Counts 0..CLK_HZ/TICK_HZ-1 while `en` = 1, then wraps to 0.
  - `tick` is asserted internally in the cycle the prescaler equals its terminal value.
- Counter:
  - On `tick`, `cntr_val` increments.
  - At FRAME_TICKS-1, `cntr_val` wraps to 0 instead; this is the frame boundary.
  - `frame_start` is registered 1 in the same clock edge where `cntr_val` loads 0 from the wrap, and 0 otherwise.
  - Reset does not produce a `frame_start` pulse.
- `en` = 0:
  - Prescaler, `cntr_val` and `x_val` hold; `frame_start` = 0.
  - Sample capture continues.
  - On `en` returning to 1, counting resumes from the held values.
- Sample capture:
  - On `spi_valid`, target <= PULSE_MIN + min(`spi_data`, PULSE_SPAN).
  - Use 12-bit internal arithmetic. Every `spi_valid` overwrites target; the last sample before a boundary wins.
- Setpoint update: only at the frame boundary edge, simultaneously with `cntr_val` loading 0. Arithmetic is 12-bit, so no underflow.
  - If target > `x_val` + SLEW_STEP: `x_val` += SLEW_STEP.
  - Else if target + SLEW_STEP < `x_val`: `x_val` -= SLEW_STEP.
  - Else: `x_val` = target.
- `x_val` never changes mid-frame and always stays within [PULSE_MIN, PULSE_MIN+PULSE_SPAN].
- Simultaneous `spi_valid` and boundary:
  - The update uses the old target.
  - The new target is captured in the same edge and applies from the next boundary.
- `slewing` = (target ≠ `x_val`), registered. It follows target and `x_val` with one cycle of latency.
- Reset mid-frame:
  - Everything returns to reset values immediately.
  - The first frame after release starts at `cntr_val` 0.
- Latency:
  - `cntr_val` advances 1 per CLK_HZ/TICK_HZ clocks.
  - A sample takes effect at the next boundary, at most FRAME_TICKS ticks later.

Test Plan:
1. Apply reset, release, hold `en` = 1.
   - `cntr_val` = 0 and `x_val` = 1500 at release.
   - `cntr_val` = 1 after 100 clocks.
   - `frame_start` pulses exactly once at clock 2,000,000 after release, with `cntr_val` = 0.
2. Pulse `spi_valid` with `spi_data` = 1023.
   - target = 2000, `slewing` = 1.
   - `x_val` stays 1500 until the next boundary.
   - `x_val` then steps 1550, 1600, … and reaches 2000 on the 10th boundary, after which `slewing` = 0.
3. From `x_val` 1500, send 520 in mid-frame.
   - `x_val` becomes 1520 exactly at the next `frame_start`, with no change before it.
   - Then send 0: `x_val` steps 1470 … and reaches 1000 after 11 frames.
4. Assert `spi_valid` (`spi_data` = 900) in the exact boundary cycle while target = 1500 and `x_val` = 1500.
   - `x_val` stays 1500 at that boundary.
   - `x_val` becomes 1550 at the following boundary.
5. With `cntr_val` = 7000, drive `en` = 0 for 5000 clocks.
   - `cntr_val`, `x_val` and the prescaler hold; no `frame_start`.
   - On `en` = 1, `cntr_val` resumes at 7000.
6. Assert `rst` = 0 asynchronously between clock edges at `cntr_val` = 12345 with `x_val` = 1800.
   - Outputs become 0 / 1500 / 0 before the next edge, with no `frame_start` pulse.

Source files
------------

// File: rtl/servo_frame_gen.sv
// Servo frame timebase: a prescaled tick counter that wraps every frame, plus a
// clamped, slew-limited pulse-width setpoint that only moves on frame boundaries.
module servo_frame_gen #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TICK_HZ     = 1_000_000,
  parameter int FRAME_TICKS = 20000,
  parameter int PULSE_MIN   = 1000,
  parameter int PULSE_SPAN  = 1000,
  parameter int SLEW_STEP   = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [9:0]  spi_data,
  input  logic        spi_valid,
  output logic [14:0] cntr_val,
  output logic [10:0] x_val,
  output logic        frame_start,
  output logic        slewing
);

  localparam int PRESC = CLK_HZ / TICK_HZ;
  localparam int PW    = $clog2(PRESC);

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
  localparam logic [14:0]   CNTR_LAST  = 15'(FRAME_TICKS - 1);
  localparam logic [11:0]   P_MIN      = 12'(PULSE_MIN);
  localparam logic [11:0]   P_SPAN     = 12'(PULSE_SPAN);
  localparam logic [11:0]   P_STEP     = 12'(SLEW_STEP);
  localparam logic [11:0]   P_MID      = 12'(PULSE_MIN + PULSE_SPAN / 2);

  logic [PW-1:0] presc_q, presc_d;
  logic [14:0]   cntr_q, cntr_d;
  logic          frame_start_q, frame_start_d;
  logic [11:0]   target_q, target_d;
  logic [11:0]   x_q, x_d;
  logic          slewing_q, slewing_d;

  logic          tick;
  logic          boundary;
  logic [11:0]   raw_ext;
  logic [11:0]   raw_clamped;

  assign tick        = en && (presc_q == PRESC_LAST);
  assign boundary    = tick && (cntr_q == CNTR_LAST);
  assign raw_ext     = {2'b00, spi_data};
  assign raw_clamped = (raw_ext > P_SPAN) ? P_SPAN : raw_ext;

  // The slew decision reads target_q, so a sample landing on the boundary
  // edge is only captured here and takes effect one frame later.
  always_comb begin
    presc_d       = presc_q;
    cntr_d        = cntr_q;
    frame_start_d = 1'b0;
    target_d      = target_q;
    x_d           = x_q;
    slewing_d     = (target_q != x_q);

    if (en) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    if (tick) begin
      cntr_d = boundary ? '0 : cntr_q + 15'd1;
    end

    if (boundary) begin
      frame_start_d = 1'b1;
      if (target_q > x_q + P_STEP) begin
        x_d = x_q + P_STEP;
      end else if (target_q + P_STEP < x_q) begin
        x_d = x_q - P_STEP;
      end else begin
        x_d = target_q;
      end
    end

    if (spi_valid) begin
      target_d = P_MIN + raw_clamped;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q       <= '0;
      cntr_q        <= '0;
      frame_start_q <= 1'b0;
      target_q      <= P_MID;
      x_q           <= P_MID;
      slewing_q     <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      cntr_q        <= cntr_d;
      frame_start_q <= frame_start_d;
      target_q      <= target_d;
      x_q           <= x_d;
      slewing_q     <= slewing_d;
    end
  end

  assign cntr_val    = cntr_q;
  assign x_val       = x_q[10:0];
  assign frame_start = frame_start_q;
  assign slewing     = slewing_q;

endmodule

// File: tb/tb_servo_frame_gen.sv
// Self-checking bench for servo_frame_gen, run with a shrunk timebase so whole
// frames fit in a few hundred clocks; expectations come from a frame-level model.
module tb_servo_frame_gen;

  localparam int PRESC      = 4;
  localparam int FRAME      = 50;
  localparam int FC         = PRESC * FRAME;
  localparam int PMIN       = 1000;
  localparam int SPAN       = 1000;
  localparam int STEP       = 50;
  localparam int MID        = PMIN + SPAN / 2;

  logic        clk;
  logic        rst;
  logic        en;
  logic [9:0]  spi_data;
  logic        spi_valid;
  logic [14:0] cntr_val;
  logic [10:0] x_val;
  logic        frame_start;
  logic        slewing;

  int n_checks = 0;
  int n_fail   = 0;

  servo_frame_gen #(
    .CLK_HZ(PRESC * 100),
    .TICK_HZ(100),
    .FRAME_TICKS(FRAME),
    .PULSE_MIN(PMIN),
    .PULSE_SPAN(SPAN),
    .SLEW_STEP(STEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .spi_data(spi_data),
    .spi_valid(spi_valid),
    .cntr_val(cntr_val),
    .x_val(x_val),
    .frame_start(frame_start),
    .slewing(slewing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the tick count is just enabled clocks divided by the
  // prescale ratio, and a boundary is every FC-th enabled clock.
  longint m_en_clks;
  int     m_target;
  int     m_x;
  logic   m_fs;
  logic   m_slew;

  always @(posedge clk or negedge rst) begin : model
    longint n;
    int     nx;
    logic   fs;
    if (!rst) begin
      m_en_clks <= 0;
      m_target  <= MID;
      m_x       <= MID;
      m_fs      <= 1'b0;
      m_slew    <= 1'b0;
    end else begin
      n  = m_en_clks + (en ? 1 : 0);
      nx = m_x;
      fs = en && (n % FC == 0);
      if (fs) begin
        if (m_target > m_x + STEP)      nx = m_x + STEP;
        else if (m_target < m_x - STEP) nx = m_x - STEP;
        else                            nx = m_target;
      end
      m_slew    <= (m_target != m_x);
      m_fs      <= fs;
      m_x       <= nx;
      m_en_clks <= n;
      if (spi_valid) m_target <= PMIN + ((int'(spi_data) > SPAN) ? SPAN : int'(spi_data));
    end
  end

  function automatic int exp_cntr();
    return int'((m_en_clks / PRESC) % FRAME);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int d);
    spi_data  = 10'(d);
    spi_valid = 1'b1;
    step(1);
    spi_valid = 1'b0;
  endtask

  task automatic wait_fs(output bit ok, output bit x_moved);
    logic [10:0] x0;
    x0      = x_val;
    ok      = 1'b0;
    x_moved = 1'b0;
    for (int i = 0; i < FC + 8; i++) begin
      step(1);
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (x_val !== x0) x_moved = 1'b1;
    end
  endtask

  task automatic test_reset();
    int clks;
    int pulses;
    int at;
    rst = 1'b0; en = 1'b1; spi_valid = 1'b0; spi_data = '0;
    step(2);
    n_checks++;
    if (cntr_val !== 15'd0 || x_val !== 11'(MID) || frame_start !== 1'b0 || slewing !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_values: cntr=%0d x=%0d fs=%0b slew=%0b, want 0/%0d/0/0",
               cntr_val, x_val, frame_start, slewing, MID);
    end
    rst = 1'b1;
    n_checks++;
    if (cntr_val !== 15'd0 || x_val !== 11'(MID)) begin
      n_fail++;
      $display("[TB] FAIL release_values: cntr=%0d x=%0d, want 0/%0d", cntr_val, x_val, MID);
    end
    step(PRESC);
    n_checks++;
    if (cntr_val !== 15'd1) begin
      n_fail++;
      $display("[TB] FAIL first_tick: cntr=%0d, want 1", cntr_val);
    end
    clks = PRESC; pulses = 0; at = -1;
    while (clks < FC + 5) begin
      step(1);
      clks++;
      if (frame_start === 1'b1) begin
        pulses++;
        at = clks;
        n_checks++;
        if (cntr_val !== 15'd0) begin
          n_fail++;
          $display("[TB] FAIL wrap_cntr: cntr=%0d, want 0", cntr_val);
        end
      end
    end
    n_checks++;
    if (pulses != 1 || at != FC) begin
      n_fail++;
      $display("[TB] FAIL first_frame_start: pulses=%0d at clock %0d, want 1 at %0d", pulses, at, FC);
    end
  endtask

  task automatic test_slew_up();
    bit ok;
    bit moved;
    int want;
    send(1023);
    step(1);
    n_checks++;
    if (slewing !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL slew_up_flag: slewing=%0b, want 1", slewing);
    end
    for (int f = 1; f <= 10; f++) begin
      wait_fs(ok, moved);
      want = (MID + STEP * f > 2000) ? 2000 : MID + STEP * f;
      n_checks++;
      if (!ok || moved || x_val !== 11'(want) || x_val !== 11'(m_x)) begin
        n_fail++;
        $display("[TB] FAIL slew_up_frame%0d: x=%0d ok=%0b moved=%0b, want %0d", f, x_val, ok, moved, want);
      end
    end
    step(2);
    n_checks++;
    if (slewing !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL slew_up_done: slewing=%0b, want 0", slewing);
    end
  endtask

  task automatic test_small_step();
    bit ok;
    bit moved;
    int want;
    send(500);
    for (int f = 0; f < 10; f++) wait_fs(ok, moved);
    n_checks++;
    if (x_val !== 11'd1500) begin
      n_fail++;
      $display("[TB] FAIL small_setup: x=%0d, want 1500", x_val);
    end
    step(FC / 2);
    send(520);
    wait_fs(ok, moved);
    n_checks++;
    if (!ok || moved || x_val !== 11'd1520) begin
      n_fail++;
      $display("[TB] FAIL small_step: x=%0d ok=%0b moved=%0b, want 1520", x_val, ok, moved);
    end
    send(0);
    for (int k = 1; k <= 11; k++) begin
      wait_fs(ok, moved);
      want = (1520 - STEP * k < PMIN) ? PMIN : 1520 - STEP * k;
      n_checks++;
      if (!ok || x_val !== 11'(want)) begin
        n_fail++;
        $display("[TB] FAIL slew_down_frame%0d: x=%0d ok=%0b, want %0d", k, x_val, ok, want);
      end
    end
  endtask

  task automatic test_boundary_capture();
    bit ok;
    bit moved;
    send(500);
    for (int f = 0; f < 10; f++) wait_fs(ok, moved);
    n_checks++;
    if (!ok || x_val !== 11'd1500) begin
      n_fail++;
      $display("[TB] FAIL boundary_setup: x=%0d ok=%0b, want 1500", x_val, ok);
    end
    step(FC - 1);
    spi_data  = 10'd900;
    spi_valid = 1'b1;
    step(1);
    spi_valid = 1'b0;
    n_checks++;
    if (frame_start !== 1'b1 || x_val !== 11'd1500) begin
      n_fail++;
      $display("[TB] FAIL boundary_same_edge: fs=%0b x=%0d, want 1/1500", frame_start, x_val);
    end
    wait_fs(ok, moved);
    n_checks++;
    if (!ok || x_val !== 11'd1550) begin
      n_fail++;
      $display("[TB] FAIL boundary_next: x=%0d ok=%0b, want 1550", x_val, ok);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 7 * FC; i++) begin
      en        = ($urandom_range(0, 15) != 0);
      spi_valid = ($urandom_range(0, 9) == 0);
      spi_data  = 10'($urandom_range(0, 1023));
      step(1);
      n_checks++;
      if (cntr_val !== 15'(exp_cntr()) || x_val !== 11'(m_x) ||
          frame_start !== m_fs || slewing !== m_slew) begin
        n_fail++;
        $display("[TB] FAIL random_cycle%0d: cntr=%0d x=%0d fs=%0b slew=%0b, want %0d/%0d/%0b/%0b",
                 i, cntr_val, x_val, frame_start, slewing, exp_cntr(), m_x, m_fs, m_slew);
      end
    end
    en = 1'b1;
    spi_valid = 1'b0;
  endtask

  task automatic test_enable_hold();
    logic [14:0] prev;
    logic [10:0] x0;
    bit          found;
    bit          bad;
    found = 1'b0;
    prev  = cntr_val;
    for (int i = 0; i < 2 * FC && !found; i++) begin
      step(1);
      if (cntr_val === 15'd30 && prev !== 15'd30) found = 1'b1;
      prev = cntr_val;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("[TB] FAIL hold_reach: cntr=%0d, want 30", cntr_val);
    end
    en  = 1'b0;
    x0  = x_val;
    bad = 1'b0;
    send(200);
    for (int i = 0; i < 500; i++) begin
      step(1);
      if (cntr_val !== 15'd30 || x_val !== x0 || frame_start !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("[TB] FAIL hold_steady: cntr=%0d x=%0d fs=%0b, want 30/%0d/0", cntr_val, x_val, frame_start, x0);
    end
    en = 1'b1;
    step(PRESC - 1);
    n_checks++;
    if (cntr_val !== 15'd30) begin
      n_fail++;
      $display("[TB] FAIL hold_presc: cntr=%0d, want 30", cntr_val);
    end
    step(1);
    n_checks++;
    if (cntr_val !== 15'd31 || cntr_val !== 15'(exp_cntr())) begin
      n_fail++;
      $display("[TB] FAIL hold_resume: cntr=%0d, want 31", cntr_val);
    end
  endtask

  task automatic test_async_reset();
    bit          ok;
    bit          moved;
    logic [14:0] prev;
    bit          found;
    send(800);
    for (int f = 0; f < 20 && x_val !== 11'd1800; f++) wait_fs(ok, moved);
    n_checks++;
    if (x_val !== 11'd1800) begin
      n_fail++;
      $display("[TB] FAIL areset_setup: x=%0d, want 1800", x_val);
    end
    found = 1'b0;
    prev  = cntr_val;
    for (int i = 0; i < 2 * FC && !found; i++) begin
      step(1);
      if (cntr_val === 15'd37 && prev !== 15'd37) found = 1'b1;
      prev = cntr_val;
    end
    #3;
    rst = 1'b0;
    #1;
    n_checks++;
    if (!found || cntr_val !== 15'd0 || x_val !== 11'(MID) || frame_start !== 1'b0 || slewing !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL areset_values: found=%0b cntr=%0d x=%0d fs=%0b slew=%0b, want 0/%0d/0/0",
               found, cntr_val, x_val, frame_start, slewing, MID);
    end
    step(2);
    rst = 1'b1;
    step(PRESC);
    n_checks++;
    if (cntr_val !== 15'd1 || frame_start !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL areset_restart: cntr=%0d fs=%0b, want 1/0", cntr_val, frame_start);
    end
  endtask

  initial begin
    rst       = 1'b0;
    en        = 1'b1;
    spi_valid = 1'b0;
    spi_data  = '0;
    test_reset();
    test_slew_up();
    test_small_step();
    test_boundary_capture();
    test_random();
    test_enable_hold();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
